// File: rtl/cpu_pkg.sv
// Shared definitions for the MEM stage: access-size codes, MEM FSM encoding,
// byte-enable patterns and the EX/MEM request record captured while an access waits.
package cpu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Link register written by jal in write-back.
  localparam logic [4:0] REG_RA = 5'd31;

  typedef struct packed {
    logic        valid;
    logic        jal;
    logic        regdst;
    logic        regwrite;
    logic        memtoreg;
    logic        memread;
    logic        memwrite;
    logic [4:0]  rd_addr;
    logic [4:0]  rt_addr;
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [1:0]  size;
    logic        is_unsigned;
  } ex_mem_t;

endpackage

// File: rtl/mem_align.sv
// Data-memory lane steering: byte enables and replicated store data for stores,
// lane extraction plus sign/zero extension for loads.
// Sub-word support is built only when MEM_BYTE_EN is defined; otherwise word-only.
module mem_align
  import cpu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

`ifdef MEM_BYTE_EN
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Select the addressed lane and build enables/data; misaligned halves/words align down.
  always_comb begin
    case (addr_lo)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    be        = BE_WORD;
    wdata     = store_data;
    load_data = rdata;
    case (size)
      SIZE_BYTE: begin
        be        = BE_BYTE0 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = is_unsigned ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      end
      SIZE_HALF: begin
        be        = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata     = {2{store_data[15:0]}};
        load_data = is_unsigned ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
      end
      SIZE_WORD: begin
        be        = BE_WORD;
        wdata     = store_data;
        load_data = rdata;
      end
      default: begin
        be        = BE_WORD;
        wdata     = store_data;
        load_data = rdata;
      end
    endcase
  end
`else
  // Word-only build: size, signedness and lane bits have no effect.
  logic unused_sel;
  assign unused_sel = ^{size, is_unsigned, addr_lo};
  assign be         = BE_WORD;
  assign wdata      = store_data;
  assign load_data  = rdata;
`endif

endmodule

// File: rtl/mem_stage.sv
// MEM stage and MEM/WB pipeline register. Issues loads/stores over a req/ready
// handshake, stalls upstream while an access is outstanding, forces completion
// after MEM_TIMEOUT wait cycles (sticky bus_err) and inserts bubbles on stall/flush.
// Optional sub-word accesses: define MEM_BYTE_EN.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
)
(
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_jal,
  input  logic        in_regdst,
  input  logic        in_regwrite,
  input  logic        in_memtoreg,
  input  logic        in_memread,
  input  logic        in_memwrite,
  input  logic [4:0]  in_rd_addr,
  input  logic [4:0]  in_rt_addr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_store_data,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic        flush,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        bus_err,
  output logic        wb_valid,
  output logic        wb_jal,
  output logic        wb_regdst,
  output logic        wb_regwrite,
  output logic        wb_memtoreg,
  output logic [4:0]  wb_rd_addr,
  output logic [4:0]  wb_rt_addr,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_alu_result
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  mem_state_t  state_reg, state_next;
  ex_mem_t     in_pkt, cap_reg, src;
  logic [7:0]  wait_cnt_reg;
  logic        kill_reg;
  logic        bus_err_reg;
  logic        memop, timeout, complete, kill_now, in_busy;
  logic [31:0] load_data;

  assign in_pkt = '{valid: in_valid, jal: in_jal, regdst: in_regdst, regwrite: in_regwrite,
                    memtoreg: in_memtoreg, memread: in_memread, memwrite: in_memwrite,
                    rd_addr: in_rd_addr, rt_addr: in_rt_addr, pc: in_pc,
                    alu_result: in_alu_result, store_data: in_store_data,
                    size: in_size, is_unsigned: in_unsigned};

  // While waiting, the bus and the MEM/WB latch are fed from the captured copy.
  assign in_busy  = (state_reg == BUSY);
  assign src      = in_busy ? cap_reg : in_pkt;
  assign memop    = in_valid & (in_memread | in_memwrite) & ~flush;
  assign timeout  = in_busy & ~dmem_ready & (wait_cnt_reg == TIMEOUT_LAST);
  assign complete = in_busy ? (dmem_ready | timeout) : (~memop | dmem_ready);
  assign kill_now = in_busy ? (kill_reg | flush) : flush;
  assign bus_err  = bus_err_reg;

  mem_align u_align (
    .size       (src.size),
    .is_unsigned(src.is_unsigned),
    .addr_lo    (src.alu_result[1:0]),
    .store_data (src.store_data),
    .rdata      (dmem_rdata),
    .be         (dmem_be),
    .wdata      (dmem_wdata),
    .load_data  (load_data)
  );

  assign dmem_addr = {src.alu_result[31:2], 2'b00};

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // FSM next state: enter BUSY on an unanswered request, leave on completion or timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (memop && !dmem_ready) state_next = BUSY;
      BUSY:    if (complete) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: request strobes are suppressed during reset so an in-flight access is dropped.
  always_comb begin
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    stall_out = ~complete;
    if (!reset) begin
      dmem_req = in_busy | memop;
      dmem_we  = (in_busy | memop) & src.memwrite;
    end
  end

  // Capture the waiting request, count wait cycles, remember a flush seen while BUSY, sticky error.
  always_ff @(posedge clock) begin
    if (reset) begin
      cap_reg      <= '0;
      wait_cnt_reg <= 8'd0;
      kill_reg     <= 1'b0;
      bus_err_reg  <= 1'b0;
    end else begin
      if (!in_busy && state_next == BUSY) cap_reg <= in_pkt;
      wait_cnt_reg <= (in_busy && state_next == BUSY) ? wait_cnt_reg + 8'd1 : 8'd0;
      kill_reg     <= in_busy && state_next == BUSY && kill_now;
      bus_err_reg  <= bus_err_reg | timeout;
    end
  end

  // MEM/WB register: latch on the completing cycle, bubble while stalled or killed.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid      <= 1'b0;
      wb_jal        <= 1'b0;
      wb_regdst     <= 1'b0;
      wb_regwrite   <= 1'b0;
      wb_memtoreg   <= 1'b0;
      wb_rd_addr    <= 5'd0;
      wb_rt_addr    <= 5'd0;
      wb_pc         <= 32'd0;
      wb_read_data  <= 32'd0;
      wb_alu_result <= 32'd0;
    end else if (stall_out) begin
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_jal      <= 1'b0;
    end else begin
      wb_valid      <= src.valid & ~kill_now;
      wb_regwrite   <= src.regwrite & src.valid & ~kill_now;
      wb_jal        <= src.jal & src.valid & ~kill_now;
      wb_regdst     <= src.regdst;
      wb_memtoreg   <= src.memtoreg;
      wb_rd_addr    <= src.rd_addr;
      wb_rt_addr    <= src.rt_addr;
      wb_pc         <= src.pc;
      wb_alu_result <= src.alu_result;
      wb_read_data  <= (timeout || !src.memread) ? 32'd0 : load_data;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus random transactions, each
// checked cycle by cycle against a transaction-level model of the MEM stage.
// Works with or without MEM_BYTE_EN defined.
module tb_mem_stage;

  localparam int T = 4;

`ifdef MEM_BYTE_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_jal, in_regdst, in_regwrite, in_memtoreg, in_memread, in_memwrite;
  logic [4:0]  in_rd_addr, in_rt_addr;
  logic [31:0] in_pc, in_alu_result, in_store_data;
  logic [1:0]  in_size;
  logic        in_unsigned, flush;
  logic        stall_out, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready, bus_err;
  logic        wb_valid, wb_jal, wb_regdst, wb_regwrite, wb_memtoreg;
  logic [4:0]  wb_rd_addr, wb_rt_addr;
  logic [31:0] wb_pc, wb_read_data, wb_alu_result;

  int n_checks = 0;
  int n_errors = 0;
  bit err_model = 1'b0;

  typedef struct {
    bit          valid, jal, regdst, regwrite, memtoreg, memread, memwrite, uns;
    logic [4:0]  rd, rt;
    logic [31:0] pc, alu, sdata, rdata;
    logic [1:0]  size;
    int          lat;       // cycle (from issue) on which ready is driven; -1 = never
    int          flush_at;  // cycle on which flush is pulsed; -1 = never
  } txn_t;

  txn_t t;

  always #5 clock = ~clock;

  mem_stage #(.MEM_TIMEOUT(T)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_jal(in_jal), .in_regdst(in_regdst), .in_regwrite(in_regwrite),
    .in_memtoreg(in_memtoreg), .in_memread(in_memread), .in_memwrite(in_memwrite),
    .in_rd_addr(in_rd_addr), .in_rt_addr(in_rt_addr), .in_pc(in_pc),
    .in_alu_result(in_alu_result), .in_store_data(in_store_data),
    .in_size(in_size), .in_unsigned(in_unsigned), .flush(flush),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .bus_err(bus_err),
    .wb_valid(wb_valid), .wb_jal(wb_jal), .wb_regdst(wb_regdst), .wb_regwrite(wb_regwrite),
    .wb_memtoreg(wb_memtoreg), .wb_rd_addr(wb_rd_addr), .wb_rt_addr(wb_rt_addr),
    .wb_pc(wb_pc), .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference lane model written from the access-size rules.
  function automatic logic [3:0] ref_be(input logic [1:0] size, input logic [31:0] a);
    int lane;
    lane = int'(a[1:0]);
    if (!BYTE_EN) return 4'hF;
    if (size == 2'd0) return 4'(1 << lane);
    if (size == 2'd1) return (lane >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] d);
    if (!BYTE_EN) return d;
    if (size == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (size == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input bit uns,
                                           input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    int lane;
    lane = int'(a[1:0]);
    if (!BYTE_EN) return rd;
    if (size == 2'd0) begin
      v = (rd >> (8 * lane)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (size == 2'd1) begin
      v = (rd >> ((lane >= 2) ? 16 : 0)) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
      return v;
    end
    return rd;
  endfunction

  task automatic drive_idle();
    in_valid = 0; in_jal = 0; in_regdst = 0; in_regwrite = 0; in_memtoreg = 0;
    in_memread = 0; in_memwrite = 0; in_rd_addr = 0; in_rt_addr = 0; in_pc = 0;
    in_alu_result = 0; in_store_data = 0; in_size = 2'd2; in_unsigned = 0;
    flush = 0; dmem_ready = 0; dmem_rdata = 0;
  endtask

  // Runs one transaction from the current negedge until its result is visible at MEM/WB.
  task automatic run_txn(input string name);
    bit memop, timed_out, fl, keep;
    int done_cyc;
    memop = t.valid && (t.memread || t.memwrite) && t.flush_at != 0;
    if (!memop)                       begin done_cyc = 0;     timed_out = 0; end
    else if (t.lat >= 0 && t.lat <= T) begin done_cyc = t.lat; timed_out = 0; end
    else                              begin done_cyc = T;     timed_out = 1; end
    fl   = (t.flush_at >= 0 && t.flush_at <= done_cyc);
    keep = t.valid && !fl;
    for (int k = 0; k <= done_cyc; k++) begin
      in_valid = t.valid; in_jal = t.jal; in_regdst = t.regdst; in_regwrite = t.regwrite;
      in_memtoreg = t.memtoreg; in_memread = t.memread; in_memwrite = t.memwrite;
      in_rd_addr = t.rd; in_rt_addr = t.rt; in_pc = t.pc; in_alu_result = t.alu;
      in_store_data = t.sdata; in_size = t.size; in_unsigned = t.uns;
      flush = (k == t.flush_at);
      dmem_ready = (k == t.lat);
      dmem_rdata = (k == t.lat) ? t.rdata : $urandom;
      #1;
      chk({name, ".req"}, 32'(dmem_req), 32'(memop));
      chk({name, ".stall"}, 32'(stall_out), 32'(k < done_cyc));
      if (memop) begin
        chk({name, ".addr"}, dmem_addr, t.alu & 32'hFFFF_FFFC);
        chk({name, ".we"}, 32'(dmem_we), 32'(t.memwrite));
        chk({name, ".be"}, 32'(dmem_be), 32'(ref_be(t.size, t.alu)));
        if (t.memwrite) chk({name, ".wdata"}, dmem_wdata, ref_wdata(t.size, t.sdata));
      end
      if (k > 0) chk({name, ".bubble"}, {29'd0, wb_valid, wb_regwrite, wb_jal}, 32'd0);
      @(negedge clock);
    end
    if (timed_out) err_model = 1'b1;
    chk({name, ".wb_valid"}, 32'(wb_valid), 32'(keep));
    chk({name, ".wb_regwrite"}, 32'(wb_regwrite), 32'(keep && t.regwrite));
    chk({name, ".wb_jal"}, 32'(wb_jal), 32'(keep && t.jal));
    if (keep) begin
      chk({name, ".wb_pc"}, wb_pc, t.pc);
      chk({name, ".wb_alu"}, wb_alu_result, t.alu);
      chk({name, ".wb_rd"}, 32'(wb_rd_addr), 32'(t.rd));
      chk({name, ".wb_rt"}, 32'(wb_rt_addr), 32'(t.rt));
      chk({name, ".wb_ctl"}, {30'd0, wb_regdst, wb_memtoreg}, {30'd0, t.regdst, t.memtoreg});
      if (t.memread)
        chk({name, ".wb_rdata"}, wb_read_data,
            timed_out ? 32'd0 : ref_load(t.size, t.uns, t.alu, t.rdata));
    end
    chk({name, ".bus_err"}, 32'(bus_err), 32'(err_model));
    $display("txn %s: memop=%0d stall_cycles=%0d timeout=%0d kept=%0d",
             name, memop, done_cyc, timed_out, keep);
  endtask

  task automatic base_txn();
    t = '{valid: 1, jal: 0, regdst: 0, regwrite: 1, memtoreg: 1, memread: 1, memwrite: 0,
          uns: 0, rd: 5'd3, rt: 5'd4, pc: 32'h0040_0010, alu: 32'h100, sdata: 32'h0,
          rdata: 32'h0, size: 2'd2, lat: 0, flush_at: -1};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pre;
    drive_idle();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    chk("reset.req", 32'(dmem_req), 32'd0);
    chk("reset.wb_valid", 32'(wb_valid), 32'd0);
    chk("reset.wb_pc", wb_pc, 32'd0);
    chk("reset.bus_err", 32'(bus_err), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // 1: zero-wait word load
    base_txn(); t.rdata = 32'h1234_5678;
    run_txn("t1_lw");
    chk("t1.rdata_const", wb_read_data, 32'h1234_5678);

    // 2: byte store at 0x103, ready after 3 cycles
    base_txn(); t.memread = 0; t.memwrite = 1; t.regwrite = 0; t.memtoreg = 0;
    t.size = 2'd0; t.alu = 32'h103; t.sdata = 32'h0000_00AB; t.lat = 3;
    run_txn("t2_sb");

`ifdef MEM_BYTE_EN
    // 3: signed and unsigned byte load from lane 1
    base_txn(); t.size = 2'd0; t.alu = 32'h101; t.rdata = 32'h0000_8000;
    run_txn("t3_lb");
    chk("t3.lb_const", wb_read_data, 32'hFFFF_FF80);
    t.uns = 1;
    run_txn("t3_lbu");
    chk("t3.lbu_const", wb_read_data, 32'h0000_0080);
`endif

    // 4: ready never arrives -> timeout, zero data, sticky error
    base_txn(); t.lat = -1;
    run_txn("t4_timeout");
    base_txn(); t.memread = 0; t.memtoreg = 0;
    run_txn("t4_sticky");

    // 5: flush in BUSY cycle 2, ready in cycle 3 with a jal-like writeback
    base_txn(); t.jal = 1; t.lat = 3; t.flush_at = 2;
    run_txn("t5_flush_busy");

    // flush while IDLE: no request, bubble
    base_txn(); t.flush_at = 0;
    run_txn("flush_idle");

    // 6: reset during BUSY
    base_txn();
    in_valid = 1; in_memread = 1; in_regwrite = 1; in_alu_result = 32'h200; in_pc = 32'h44;
    dmem_ready = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("t6.req_in_reset", 32'(dmem_req), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    drive_idle();
    err_model = 1'b0;
    #1;
    chk("t6.wb_valid", 32'(wb_valid), 32'd0);
    chk("t6.wb_regwrite", 32'(wb_regwrite), 32'd0);
    chk("t6.wb_pc", wb_pc, 32'd0);
    chk("t6.bus_err", 32'(bus_err), 32'd0);
    chk("t6.stall", 32'(stall_out), 32'd0);
    @(negedge clock);
    base_txn(); t.rdata = 32'hCAFE_F00D;
    run_txn("t6_after");

    // Random transactions
    for (int i = 0; i < 60; i++) begin
      int op, r;
      op = int'($urandom_range(2));
      r  = int'($urandom_range(6));
      t.valid    = ($urandom_range(9) != 0);
      t.jal      = ($urandom_range(3) == 0);
      t.regdst   = $urandom_range(1) == 1;
      t.regwrite = $urandom_range(1) == 1;
      t.memtoreg = $urandom_range(1) == 1;
      t.memread  = (op == 1);
      t.memwrite = (op == 2);
      t.uns      = $urandom_range(1) == 1;
      t.rd       = 5'($urandom);
      t.rt       = 5'($urandom);
      t.pc       = $urandom & 32'hFFFF_FFFC;
      t.alu      = $urandom;
      t.sdata    = $urandom;
      t.rdata    = $urandom;
      t.size     = 2'($urandom_range(2));
      t.lat      = (r == 6) ? -1 : r;
      pre = (t.valid && op != 0) ? ((t.lat >= 0 && t.lat <= T) ? t.lat : T) : 0;
      t.flush_at = ($urandom_range(4) == 0) ? int'($urandom_range(pre)) : -1;
      run_txn($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
